// File: rtl/gcd_stein_param_if.sv
// Handshake/operand bundle for the Stein GCD engine.
// The controller drives start/xi/yi; the engine returns busy/done/xo/cyc.
interface gcd_stein_param_if #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(4*WIDTH+4)
);
  logic             start;
  logic [WIDTH-1:0] xi;
  logic [WIDTH-1:0] yi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] xo;
  logic [CW-1:0]    cyc;

  modport master (output start, xi, yi, input  busy, done, xo, cyc);
  modport slave  (input  start, xi, yi, output busy, done, xo, cyc);
endinterface

// File: rtl/gcd_stein_param.sv
// Iterative binary (Stein) GCD: shift/subtract only, one step per clock.
// Operands are captured raw in IDLE; magnitudes are taken in LOAD.
module gcd_stein_param #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 1,
  parameter int CW     = $clog2(4*WIDTH+4)
) (
  input  logic              clk,
  input  logic              rst,
  gcd_stein_param_if.slave  io
);
  localparam int KW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a, b;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] xo_r;
  logic [CW-1:0]    cyc_r;
  logic [WIDTH-1:0] ma, mb;

  // Unsigned negate keeps -2^(WIDTH-1) as 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (SIGNED != 0 && v[WIDTH-1]) return ~v + WIDTH'(1);
    return v;
  endfunction

  always_comb begin
    ma = mag(a);
    mb = mag(b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      xo_r   <= '0;
      cyc_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            a      <= io.xi;
            b      <= io.yi;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          a   <= ma;
          b   <= mb;
          k   <= '0;
          cnt <= '0;
          // A zero operand never enters RUN, which keeps a nonzero there.
          if (ma == '0 || mb == '0) begin
            xo_r   <= (ma == '0) ? mb : ma;
            cyc_r  <= '0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (b == '0) begin
            xo_r   <= a << k;
            cyc_r  <= cnt + CW'(1);
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + KW'(1);
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy = busy_r;
  assign io.done = done_r;
  assign io.xo   = xo_r;
  assign io.cyc  = cyc_r;
endmodule
